// File: rtl/mig_app_responder.sv
`timescale 1ns/1ps
// mig_app_responder
// Stands in for the MIG 7-series DDR3 controller (app_* interface, 4:1 mode).
// It stores words in on-chip RAM and returns read data in command order.
// After reset it holds both ready outputs low for a calibration period.
// app_rdy can optionally be dropped one cycle in every RDY_PERIOD, so that
// initiator flow control gets exercised.
//
// Ports
//   uiclk, reset         clock; synchronous active-high reset
//   app_addr/cmd/en      command channel; app_rdy is the accept strobe
//   app_wdf_*            write-data channel; app_wdf_rdy is the accept strobe
//   app_rd_data*         read return, one valid cycle per read, in order
//   init_calib_complete  high once calibration has finished (RUN state)
//   err                  sticky protocol error flag
//   state_dbg            current FSM state (0 = CALIB, 1 = RUN)
//
// Handshake: a command is taken on a rising edge where app_en && app_rdy.
// A data beat is taken where app_wdf_wren && app_wdf_rdy. Neither ready
// depends on the matching valid. The initiator holds its valid and payload
// stable until the beat or command is taken.
module mig_app_responder #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 128,
    parameter int RD_LATENCY   = 4,
    parameter int RDY_PERIOD   = 0,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                    uiclk,
    input  logic                    reset,
    input  logic [27:0]             app_addr,
    input  logic [2:0]              app_cmd,
    input  logic                    app_en,
    output logic                    app_rdy,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
    output logic                    init_calib_complete,
    output logic                    err,
    output logic [0:0]              state_dbg
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [15:0] CALIB_LAST = 16'(CALIB_CYCLES - 1);
    localparam bit          THR_EN     = (RDY_PERIOD >= 2);
    localparam logic [15:0] THR_LAST   = THR_EN ? 16'(RDY_PERIOD - 1) : 16'd0;

    typedef enum logic {
        CALIB = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state, state_next;
    logic [15:0] calib_cnt;
    logic [15:0] thr_cnt;
    logic        run;
    logic        throttle;

    // ---------------- FSM ----------------
    always_ff @(posedge uiclk) begin
        if (reset) state <= CALIB;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CALIB:   if (calib_cnt == CALIB_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CALIB;
        endcase
    end

    assign run       = (state == RUN);
    assign state_dbg = state;

    // Calibration counter
    always_ff @(posedge uiclk) begin
        if (reset)
            calib_cnt <= '0;
        else if (state == CALIB && calib_cnt != CALIB_LAST)
            calib_cnt <= calib_cnt + 16'd1;
    end

    // Throttle counter. It starts at 0 on the first RUN cycle and runs freely.
    // app_rdy is dropped in the last slot of each period.
    always_ff @(posedge uiclk) begin
        if (reset)
            thr_cnt <= '0;
        else if (run)
            thr_cnt <= (thr_cnt == THR_LAST) ? 16'd0 : thr_cnt + 16'd1;
    end

    assign throttle = THR_EN && (thr_cnt == THR_LAST);

    // ---------------- queues ----------------
    logic                  cq_rd   [4];
    logic [ADDR_WIDTH-1:0] cq_addr [4];
    logic [1:0]            cq_wp, cq_rp;
    logic [2:0]            cq_cnt;

    logic [DATA_WIDTH-1:0] wq_data [4];
    logic [MASK_WIDTH-1:0] wq_mask [4];
    logic [1:0]            wq_wp, wq_rp;
    logic [2:0]            wq_cnt;

    logic cmd_acc, cmd_legal, cq_push, cq_pop, wq_push, wq_pop;
    logic exec_rd, exec_wr;

    assign app_rdy     = run && (cq_cnt != 3'd4) && !throttle;
    assign app_wdf_rdy = run && (wq_cnt != 3'd4);

    assign cmd_acc   = app_en && app_rdy;
    assign cmd_legal = (app_cmd == 3'b000) || (app_cmd == 3'b001);
    // Illegal commands are taken (accept strobe fires) but never queued
    assign cq_push   = cmd_acc && cmd_legal;
    assign wq_push   = app_wdf_wren && app_wdf_rdy;

    // The head executes one entry per cycle. A write stalls until its data beat is present.
    assign exec_rd = (cq_cnt != 3'd0) && cq_rd[cq_rp];
    assign exec_wr = (cq_cnt != 3'd0) && !cq_rd[cq_rp] && (wq_cnt != 3'd0);
    assign cq_pop  = exec_rd || exec_wr;
    assign wq_pop  = exec_wr;

    always_ff @(posedge uiclk) begin
        if (reset) begin
            cq_wp  <= '0;
            cq_rp  <= '0;
            cq_cnt <= '0;
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
        end else begin
            if (cq_push) cq_wp <= cq_wp + 2'd1;
            if (cq_pop)  cq_rp <= cq_rp + 2'd1;
            if (cq_push && !cq_pop)      cq_cnt <= cq_cnt + 3'd1;
            else if (!cq_push && cq_pop) cq_cnt <= cq_cnt - 3'd1;

            if (wq_push) wq_wp <= wq_wp + 2'd1;
            if (wq_pop)  wq_rp <= wq_rp + 2'd1;
            if (wq_push && !wq_pop)      wq_cnt <= wq_cnt + 3'd1;
            else if (!wq_push && wq_pop) wq_cnt <= wq_cnt - 3'd1;
        end
    end

    // Queue storage needs no reset; only the pointers define occupancy
    always_ff @(posedge uiclk) begin
        if (cq_push) begin
            cq_rd[cq_wp]   <= app_cmd[0];
            cq_addr[cq_wp] <= app_addr[ADDR_WIDTH+2:3];
        end
        if (wq_push) begin
            wq_data[wq_wp] <= app_wdf_data;
            wq_mask[wq_wp] <= app_wdf_mask;
        end
    end

    // ---------------- error flag ----------------
    always_ff @(posedge uiclk) begin
        if (reset)
            err <= 1'b0;
        else if ((cmd_acc && (!cmd_legal || app_addr[2:0] != 3'b000)) ||
                 (wq_push && !app_wdf_end))
            err <= 1'b1;
    end

    // ---------------- storage ----------------
    // Contents survive reset. The write is gated during reset so that a
    // stale queue head cannot corrupt memory.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge uiclk) begin
        if (exec_wr && !reset) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!wq_mask[wq_rp][b])
                    mem[cq_addr[cq_rp]][8*b +: 8] <= wq_data[wq_rp][8*b +: 8];
            end
        end
    end

    // ---------------- read pipeline ----------------
    // Stage 0 captures at the execute edge. Stage RD_LATENCY drives the outputs.
    logic [RD_LATENCY:0]   rd_vld;
    logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY+1];

    always_ff @(posedge uiclk) begin
        if (reset) begin
            rd_vld <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) rd_pipe[i] <= '0;
        end else begin
            rd_vld <= {rd_vld[RD_LATENCY-1:0], exec_rd};
            if (exec_rd) rd_pipe[0] <= mem[cq_addr[cq_rp]];
            for (int i = 1; i <= RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign app_rd_data         = rd_pipe[RD_LATENCY];
    assign app_rd_data_valid   = rd_vld[RD_LATENCY];
    assign app_rd_data_end     = rd_vld[RD_LATENCY];
    assign init_calib_complete = run;

    // Address bits above the word index are ignored; the addresses alias
    logic unused_addr;
    assign unused_addr = ^app_addr[27:ADDR_WIDTH+3];

endmodule

// File: tb/tb_mig_app_responder.sv
`timescale 1ns/1ps
// Testbench for mig_app_responder (RDY_PERIOD = 4).
// The reference model is a transaction-ordered memory. Expected read data is
// queued as soon as it becomes determinable, and a negedge monitor pops and
// compares every read return.
module tb_mig_app_responder;
    localparam int AW = 8;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int RL = 4;
    localparam int RP = 4;
    localparam int CC = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [27:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic          init_calib_complete;
    logic          err;
    logic [0:0]    state_dbg;

    mig_app_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL),
        .RDY_PERIOD(RP), .CALIB_CYCLES(CC)
    ) dut (
        .uiclk(clk), .reset(reset),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
        .err(err), .state_dbg(state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mmem [256];
    bit            mc_rd_q [$];
    logic [7:0]    mc_a_q  [$];
    logic [DW-1:0] md_d_q  [$];
    logic [MW-1:0] md_m_q  [$];
    logic [DW-1:0] exp_q   [$];
    bit            exp_err = 1'b0;

    // Retire commands in order, as far as the available data allows
    task automatic model_step();
        while (mc_rd_q.size() > 0) begin
            if (mc_rd_q[0]) begin
                exp_q.push_back(mmem[mc_a_q[0]]);
                void'(mc_rd_q.pop_front());
                void'(mc_a_q.pop_front());
            end else if (md_d_q.size() > 0) begin
                for (int b = 0; b < MW; b++)
                    if (!md_m_q[0][b]) mmem[mc_a_q[0]][8*b +: 8] = md_d_q[0][8*b +: 8];
                void'(mc_rd_q.pop_front());
                void'(mc_a_q.pop_front());
                void'(md_d_q.pop_front());
                void'(md_m_q.pop_front());
            end else begin
                break;
            end
        end
    endtask

    task automatic model_cmd(input logic [2:0] c, input logic [27:0] a);
        if (a[2:0] != 3'b000) exp_err = 1'b1;
        if (c == 3'b000 || c == 3'b001) begin
            mc_rd_q.push_back(c == 3'b001);
            mc_a_q.push_back(a[10:3]);
        end else begin
            exp_err = 1'b1;
        end
        model_step();
    endtask

    task automatic model_dat(input logic [DW-1:0] d, input logic [MW-1:0] m);
        md_d_q.push_back(d);
        md_m_q.push_back(m);
        model_step();
    endtask

    // ---------------- monitors ----------------
    int valid_count    = 0;
    int last_valid_cyc = 0;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (app_rd_data_valid) begin
            valid_count++;
            last_valid_cyc = cyc;
            check(app_rd_data_end == 1'b1, "rd_end", DW'(app_rd_data_end), DW'(1));
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_valid", app_rd_data, '0);
            end else begin
                e = exp_q.pop_front();
                check(app_rd_data === e, "rd_data", app_rd_data, e);
            end
        end
    end

    // The throttle slot is counted from the first cycle in which calibration is complete
    bit thr_on = 1'b0;
    int run_k  = 0;
    always @(negedge clk) begin
        if (thr_on)
            check(app_rdy == ((run_k % RP) != RP - 1), "throttle", DW'(app_rdy), DW'((run_k % RP) != RP - 1));
        if (init_calib_complete) run_k++;
        else run_k = 0;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [27:0] mk_addr(input int w);
        return {17'($urandom), 8'(w), 3'b000};
    endfunction

    // Call at a negedge. Holds each requested channel until it is accepted.
    // acc returns the cycle number of the command's accept edge.
    task automatic drive(input bit dc, input logic [2:0] c, input logic [27:0] a,
                         input bit dd, input logic [DW-1:0] d, input logic [MW-1:0] m,
                         output int acc);
        int  guard = 0;
        bit  cg, dg;
        acc = -1;
        app_en = dc; app_cmd = c; app_addr = a;
        app_wdf_wren = dd; app_wdf_end = dd; app_wdf_data = d; app_wdf_mask = m;
        while ((app_en || app_wdf_wren) && guard < 200) begin
            cg = app_en && app_rdy;
            dg = app_wdf_wren && app_wdf_rdy;
            if (cg) acc = cyc + 1;
            @(posedge clk);
            if (cg) model_cmd(c, a);
            if (dg) model_dat(d, m);
            @(negedge clk);
            if (cg) app_en = 1'b0;
            if (dg) begin app_wdf_wren = 1'b0; app_wdf_end = 1'b0; end
            guard++;
        end
        if (app_en || app_wdf_wren) begin
            n_checks++;
            $display("FAIL drive_timeout: handshake not completed after %0d cycles", guard);
            app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        thr_on = 1'b0;
        exp_q.delete(); mc_rd_q.delete(); mc_a_q.delete(); md_d_q.delete(); md_m_q.delete();
        exp_err = 1'b0;
    endtask

    // Call at the negedge where reset is released
    task automatic wait_calib();
        int n = 0;
        while (!init_calib_complete && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check(n == CC, "calib_cycles", DW'(n), DW'(CC));
        check(app_rdy && app_wdf_rdy, "rdy_after_calib", DW'({app_rdy, app_wdf_rdy}), DW'(2'b11));
        check(state_dbg == 1'b1, "state_run", DW'(state_dbg), DW'(1));
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk); #1;
            g++;
        end
        check(exp_q.size() == 0, "drain", DW'(exp_q.size()), '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc, acc_r, vc0, g, r, w;
        logic [DW-1:0] d;
        app_en = 1'b0; app_cmd = '0; app_addr = '0;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;

        // 1: reset values and calibration
        repeat (3) @(negedge clk);
        check(app_rdy == 1'b0, "rst_app_rdy", DW'(app_rdy), '0);
        check(app_wdf_rdy == 1'b0, "rst_wdf_rdy", DW'(app_wdf_rdy), '0);
        check(app_rd_data == '0, "rst_rd_data", app_rd_data, '0);
        check(app_rd_data_valid == 1'b0, "rst_valid", DW'(app_rd_data_valid), '0);
        check(init_calib_complete == 1'b0, "rst_calib", DW'(init_calib_complete), '0);
        check(err == 1'b0, "rst_err", DW'(err), '0);
        reset = 1'b0;
        wait_calib();

        // 2: write with same-cycle data, then read back, checking latency
        drive(1, 3'b000, 28'h18, 1, {16{8'hA5}}, '0, acc);
        vc0 = valid_count;
        drive(1, 3'b001, 28'h18, 0, '0, '0, acc_r);
        g = 0;
        while (valid_count == vc0 && g < 50) begin @(negedge clk); #1; g++; end
        check(last_valid_cyc == acc_r + 1 + RL, "rd_latency", DW'(last_valid_cyc), DW'(acc_r + 1 + RL));

        // 3: write command whose data arrives 3 cycles later, with a read queued behind it
        d = rnd_word();
        drive(1, 3'b000, 28'h08, 0, '0, '0, acc);
        drive(1, 3'b001, 28'h08, 0, '0, '0, acc);
        repeat (2) @(negedge clk);
        drive(0, 3'b000, '0, 1, d, '0, acc);
        wait_drain();

        // 4: four data-less writes fill the command queue
        for (int i = 0; i < 4; i++) drive(1, 3'b000, mk_addr(32 + i), 0, '0, '0, acc);
        for (int i = 0; i < 8; i++) begin
            check(app_rdy == 1'b0, "full_rdy_low", DW'(app_rdy), '0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) drive(0, 3'b000, '0, 1, rnd_word(), '0, acc);
        g = 0;
        while (!app_rdy && g < 10) begin @(negedge clk); g++; end
        check(app_rdy == 1'b1, "rdy_returns", DW'(app_rdy), DW'(1));
        drive(1, 3'b000, mk_addr(36), 1, rnd_word(), '0, acc);
        for (int i = 0; i < 5; i++) drive(1, 3'b001, mk_addr(32 + i), 0, '0, '0, acc);
        wait_drain();

        // Fill words 0..31 completely so that later masked writes have a defined base
        for (int i = 0; i < 32; i++) drive(1, 3'b000, mk_addr(i), 1, rnd_word(), '0, acc);

        // 5: continuous reads 0..31 with the throttle pattern checked each cycle
        repeat (10) @(negedge clk);
        thr_on = 1'b1;
        for (int i = 0; i < 32; i++) drive(1, 3'b001, mk_addr(i), 0, '0, '0, acc);
        thr_on = 1'b0;
        wait_drain();

        // Randomised mix: reads, masked writes, and data ahead of its command
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 31);
            if (r <= 3) begin
                drive(1, 3'b001, mk_addr(w), 0, '0, '0, acc);
            end else if (r <= 7) begin
                drive(1, 3'b000, mk_addr(w), 1, rnd_word(), MW'($urandom), acc);
            end else if (r == 8) begin
                drive(0, 3'b000, '0, 1, rnd_word(), MW'($urandom), acc);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                drive(1, 3'b000, mk_addr(w), 0, '0, '0, acc);
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        wait_drain();
        check(err == exp_err, "err_clean", DW'(err), DW'(exp_err));

        // 6: illegal command and unaligned address set the sticky error
        drive(1, 3'b010, 28'h20, 0, '0, '0, acc);
        check(err == 1'b1, "err_illegal_cmd", DW'(err), DW'(1));
        d = rnd_word();
        drive(1, 3'b000, 28'h01, 1, d, '0, acc);
        drive(1, 3'b001, 28'h00, 0, '0, '0, acc);
        wait_drain();
        repeat (5) @(negedge clk);
        check(err == exp_err, "err_sticky", DW'(err), DW'(exp_err));

        // Reset while a read is in flight; its result must never appear
        drive(1, 3'b001, mk_addr(2), 0, '0, '0, acc);
        @(negedge clk);
        apply_reset();
        vc0 = valid_count;
        repeat (3) @(negedge clk);
        check(err == 1'b0, "err_cleared", DW'(err), '0);
        check(init_calib_complete == 1'b0, "calib_cleared", DW'(init_calib_complete), '0);
        reset = 1'b0;
        wait_calib();
        check(valid_count == vc0, "no_valid_after_reset", DW'(valid_count), DW'(vc0));

        // Memory contents survive reset
        drive(1, 3'b001, mk_addr(2), 0, '0, '0, acc);
        drive(1, 3'b001, mk_addr(0), 0, '0, '0, acc);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
